// File: rtl/xoodyak_digest_collector.sv
// Assembles the XOODYAK serial hash byte stream into a DIGEST_BYTES digest (first byte in MSBs).
// Optional digest compare against exp_digest is enabled by defining XOODYAK_DIGEST_CMP_EN.
module xoodyak_digest_collector #(
    parameter int unsigned DIGEST_BYTES   = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 6
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      arm,
    input  logic                      hash_valid,
    input  logic [7:0]                hash_byte,
    input  logic [7:0]                hash_len,
    input  logic [8*DIGEST_BYTES-1:0] exp_digest,
    output logic                      busy,
    output logic                      done,
    output logic                      digest_valid,
    output logic [8*DIGEST_BYTES-1:0] digest,
    output logic [CNT_W-1:0]          byte_cnt,
    output logic                      timeout,
    output logic                      overrun,
    output logic                      len_err,
    output logic                      match,
    output logic                      mismatch
);

    localparam int unsigned DW = 8 * DIGEST_BYTES;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COLLECT, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [DW-1:0]    digest_nxt, shifted;
    logic [CNT_W-1:0] cnt_nxt;
    logic             busy_nxt, done_nxt, dvalid_nxt;
    logic             timeout_nxt, overrun_nxt, len_err_nxt;
    logic             expired;
`ifdef XOODYAK_DIGEST_CMP_EN
    logic             match_nxt, mismatch_nxt;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= S_IDLE;
            timer        <= '0;
            digest       <= '0;
            byte_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            digest_valid <= 1'b0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            digest       <= digest_nxt;
            byte_cnt     <= cnt_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            digest_valid <= dvalid_nxt;
            timeout      <= timeout_nxt;
            overrun      <= overrun_nxt;
            len_err      <= len_err_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        digest_nxt  = digest;
        cnt_nxt     = byte_cnt;
        done_nxt    = 1'b0;
        timeout_nxt = timeout;
        overrun_nxt = overrun;
        len_err_nxt = len_err;
`ifdef XOODYAK_DIGEST_CMP_EN
        match_nxt    = match;
        mismatch_nxt = mismatch;
`endif
        shifted = {digest[DW-9:0], hash_byte};
        expired = (timer == TW'(TIMEOUT_CYCLES - 1));

        if (arm) begin
            // arm has priority; a coincident byte is dropped
            state_nxt   = S_WAIT;
            timer_nxt   = '0;
            digest_nxt  = '0;
            cnt_nxt     = '0;
            timeout_nxt = 1'b0;
            overrun_nxt = 1'b0;
            len_err_nxt = 1'b0;
`ifdef XOODYAK_DIGEST_CMP_EN
            match_nxt    = 1'b0;
            mismatch_nxt = 1'b0;
`endif
        end else begin
            case (state)
                S_WAIT, S_COLLECT: begin
                    if (hash_valid) begin
                        digest_nxt = shifted;
                        timer_nxt  = '0;
                        if (state == S_WAIT) begin
                            cnt_nxt     = CNT_W'(1);
                            len_err_nxt = (hash_len != 8'(DIGEST_BYTES));
                            state_nxt   = S_COLLECT;
                        end else begin
                            cnt_nxt = byte_cnt + CNT_W'(1);
                            if (byte_cnt == CNT_W'(DIGEST_BYTES - 1)) begin
                                state_nxt = S_DONE;
                                done_nxt  = 1'b1;
`ifdef XOODYAK_DIGEST_CMP_EN
                                match_nxt    = (shifted == exp_digest);
                                mismatch_nxt = (shifted != exp_digest);
`endif
                            end
                        end
                    end else if (expired) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = S_IDLE;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                S_DONE: begin
                    if (hash_valid) overrun_nxt = 1'b1;
                end
                default: ;
            endcase
        end

        busy_nxt   = (state_nxt == S_WAIT) || (state_nxt == S_COLLECT);
        dvalid_nxt = (state_nxt == S_DONE);
    end

`ifdef XOODYAK_DIGEST_CMP_EN
    // Compare result captured on entry to DONE
    always_ff @(posedge clk) begin
        if (!resetn) begin
            match    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            match    <= match_nxt;
            mismatch <= mismatch_nxt;
        end
    end
`else
    logic unused_exp_digest;
    assign unused_exp_digest = ^exp_digest;
    assign match    = 1'b0;
    assign mismatch = 1'b0;
`endif

endmodule

// File: doc/xoodyak_digest_collector.md
Name: xoodyak_digest_collector

Overview:
- Receiving end of the XOODYAK hash output stream.
- Captures the serial byte stream (hash, valid) from the XOODYAK core and assembles a DIGEST_BYTES-byte digest, first byte in the MSBs.
- Reports completion, timeout and overrun, and optionally compares the digest against an expected value.
- Sits between the XOODYAK core and the host/status logic, replacing bench-side digest collection in the synthesized design.

Parameters:
- DIGEST_BYTES, 32, digest length in bytes; legal range 2..32.
- TIMEOUT_CYCLES, 4096, idle cycles allowed between arm/bytes before abort; must be >= 2.
- CNT_W, 6, width of byte_cnt; must hold DIGEST_BYTES.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- arm  in  1  one-cycle pulse: clear and start a new capture.
- hash_valid  in  1  byte strobe from XOODYAK core.
- hash_byte  in  8  digest byte, qualified by hash_valid.
- hash_len  in  8  core-reported digest length in bytes.
- exp_digest  in  8*DIGEST_BYTES  expected digest, compare feature only.
- busy  out  1  high in WAIT or COLLECT.
- done  out  1  one-cycle pulse when the final byte has been captured.
- digest_valid  out  1  level, high in DONE.
- digest  out  8*DIGEST_BYTES  assembled digest.
- byte_cnt  out  CNT_W  bytes captured since the last arm.
- timeout  out  1  sticky until next arm/reset.
- overrun  out  1  sticky: byte received while in DONE.
- len_err  out  1  sticky: hash_len != DIGEST_BYTES when the first byte is sampled.
- match  out  1  digest == exp_digest, valid in DONE.
- mismatch  out  1  digest != exp_digest, valid in DONE.

Behaviour:
- Reset (resetn=0 at posedge):
  - All outputs 0, digest 0.
  - State IDLE, timer 0.
  - Reset mid-capture discards all progress.
- States: IDLE, WAIT, COLLECT, DONE; all outputs registered.
- arm, in any state:
  - Clears digest, byte_cnt, timer, timeout, overrun, len_err, match, mismatch.
  - Next state WAIT.
  - arm wins over a simultaneous hash_valid; that byte is dropped.
- IDLE: hash_valid ignored, no flag change.
- WAIT:
  - On hash_valid: digest <= {digest[8*DIGEST_BYTES-9:0], hash_byte}; byte_cnt <= 1; timer <= 0.
  - Same edge: len_err <= (hash_len != DIGEST_BYTES).
  - Next state COLLECT.
- COLLECT:
  - Each hash_valid shifts the byte in the same way and increments byte_cnt.
  - When byte_cnt == DIGEST_BYTES-1 and hash_valid: capture the byte, byte_cnt <= DIGEST_BYTES, go to DONE.
  - done=1 and digest_valid=1 in the first DONE cycle, i.e. latency of 1 edge from the last byte.
- Timer:
  - In WAIT/COLLECT, increments on every cycle without hash_valid; cleared on hash_valid.
  - When timer == TIMEOUT_CYCLES-1 with no hash_valid: timeout <= 1, go to IDLE.
  - On timeout, digest and byte_cnt keep their partial values and digest_valid stays 0.
  - A hash_valid arriving in the expiry cycle wins; no timeout occurs.
- DONE:
  - Holds digest and digest_valid; done deasserts after 1 cycle.
  - hash_valid sets overrun; digest and byte_cnt stay unchanged.
  - Only arm (or reset) leaves DONE.
- Gaps of any length below the timeout between bytes are legal; back-to-back bytes are accepted every cycle.
- byte_cnt never exceeds DIGEST_BYTES; no wrap.

Optional Feature:
- Macro: XOODYAK_DIGEST_CMP_EN.
- Defined:
  - On the cycle entering DONE, match <= (assembled digest == exp_digest) and mismatch <= its inverse.
  - Both are cleared by arm/reset and held while in DONE.
  - exp_digest must be stable from arm until done.
- Not defined:
  - match and mismatch are tied 0.
  - exp_digest is unused and no comparator is instantiated.

Test Plan:
- Nominal: reset; arm; 32 back-to-back bytes fc,c4,d6,39,...,46,15 with hash_len=32 -> done pulses 1 cycle after byte 32; digest=256'hfcc4d63932d98c30cab597e60b7cca475bd9fbf984838c5cb5615c949f814615; byte_cnt=32; len_err=0; with macro and exp_digest equal -> match=1, mismatch=0.
- Gapped: same bytes with 0..5 idle cycles between them (TIMEOUT_CYCLES=16) -> identical digest, no timeout; exp_digest with its LSB flipped -> mismatch=1.
- Timeout: TIMEOUT_CYCLES=16; arm, 10 bytes, then silence -> timeout=1 16 cycles after the 10th byte; state IDLE; byte_cnt=10; digest_valid=0; later bytes ignored.
- Overrun/arm priority: after done, send 1 extra byte 8'hAA -> overrun=1, digest unchanged; then arm together with hash_valid -> all flags cleared, byte_cnt=0, byte dropped.
- Length error: hash_len=16 with 32 bytes -> len_err=1, capture still completes with done.
- Reset mid-capture: resetn=0 after byte 7 -> all outputs 0 on the next edge; post-reset hash_valid ignored until arm.
